nibble_mayor_2in: RTL and testbench

NIBBLE_MAYOR_2IN -- requirements
Module: nibble_mayor_2in

---
 rtl/nibble_mayor_2in.sv | 55 +++++
 tb/tb_nibble_mayor_2in.sv | 124 ++++++++++++
 2 files changed

// File: rtl/nibble_mayor_2in.sv
// nibble_mayor_2in: registered unsigned maximum of two 4-bit operands.
// The magnitude compare walks the bits MSB-first, keeping per-bit "a greater",
// "b greater" and "equal so far" flags. The first differing bit decides which
// operand wins. The selected operand is registered, so there is exactly one
// clock of latency and no combinational path from the inputs to the output.
module nibble_mayor_2in (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] nm2_a,
  input  logic [3:0] nm2_b,
  output logic [3:0] nm2_mayor
);

  logic [3:0] a_gt_bit;
  logic [3:0] b_gt_bit;
  logic [4:0] eq_so_far;
  logic       a_greater;
  logic       b_greater;
  logic       pick_a;
  logic [3:0] mayor_next;
  logic [3:0] mayor_reg;

  // MSB-first compare chain: a bit only decides while all higher bits matched
  always_comb begin
    a_gt_bit     = 4'b0000;
    b_gt_bit     = 4'b0000;
    eq_so_far    = 5'b00000;
    eq_so_far[4] = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      a_gt_bit[i]  = eq_so_far[i+1] &  nm2_a[i] & ~nm2_b[i];
      b_gt_bit[i]  = eq_so_far[i+1] & ~nm2_a[i] &  nm2_b[i];
      eq_so_far[i] = eq_so_far[i+1] & ~(nm2_a[i] ^ nm2_b[i]);
    end
  end

  // Final select: take a when it won a bit or the operands are fully equal
  always_comb begin
    a_greater  = |a_gt_bit;
    b_greater  = |b_gt_bit;
    pick_a     = (a_greater | eq_so_far[0]) & ~b_greater;
    mayor_next = pick_a ? nm2_a : nm2_b;
  end

  // Result register, cleared asynchronously so a pending result is discarded
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mayor_reg <= 4'h0;
    end else begin
      mayor_reg <= mayor_next;
    end
  end

  assign nm2_mayor = mayor_reg;

endmodule

// File: tb/tb_nibble_mayor_2in.sv
// Directed testbench for nibble_mayor_2in: reset, boundaries, full sweep,
// latency/hold with mid-cycle glitches, and asynchronous reset mid-run.
module tb_nibble_mayor_2in;

  logic       clk;
  logic       reset_L;
  logic [3:0] nm2_a;
  logic [3:0] nm2_b;
  logic [3:0] nm2_mayor;

  int checks;
  int failures;

  nibble_mayor_2in dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .nm2_a     (nm2_a),
    .nm2_b     (nm2_b),
    .nm2_mayor (nm2_mayor)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference maximum, written as a plain magnitude compare
  function automatic logic [3:0] ref_max(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return a;
    return b;
  endfunction

  // Single checking point for every comparison
  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
    end
  endtask

  // Drive a pair on the falling edge, then wait past the next rising edge
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    nm2_a = a;
    nm2_b = b;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] bnd_a [6] = '{4'h0, 4'hF, 4'h0, 4'h7, 4'h8, 4'hA};
  logic [3:0] bnd_b [6] = '{4'h0, 4'h0, 4'hF, 4'h8, 4'h7, 4'hA};
  logic [3:0] bnd_e [6] = '{4'h0, 4'hF, 4'hF, 4'h8, 4'h8, 4'hA};

  initial begin
    checks   = 0;
    failures = 0;
    reset_L  = 1'b0;
    nm2_a    = 4'h3;
    nm2_b    = 4'h9;

    // Reset held for two clocks: output stays zero
    #1;
    checkOutput("reset_initial", nm2_mayor, 4'h0);
    @(posedge clk); #1;
    checkOutput("reset_edge1", nm2_mayor, 4'h0);
    @(posedge clk); #1;
    checkOutput("reset_edge2", nm2_mayor, 4'h0);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    checkOutput("reset_release_hold", nm2_mayor, 4'h0);
    @(posedge clk); #1;
    checkOutput("reset_first_load", nm2_mayor, 4'h9);

    // Boundary pairs
    for (int i = 0; i < 6; i++) begin
      applyStimulus(bnd_a[i], bnd_b[i]);
      checkOutput($sformatf("boundary_%0d", i), nm2_mayor, bnd_e[i]);
    end

    // Exhaustive sweep, one pair per clock
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'(a), 4'(b));
        checkOutput($sformatf("sweep_%h_%h", a, b), nm2_mayor,
                    ref_max(4'(a), 4'(b)));
      end
    end

    // Latency and hold: mid-cycle glitches must not reach the output
    applyStimulus(4'h5, 4'h2);
    checkOutput("latency_first", nm2_mayor, 4'h5);
    nm2_a = 4'hF; nm2_b = 4'hF;
    #2;
    checkOutput("hold_glitch_ff", nm2_mayor, 4'h5);
    nm2_a = 4'h0; nm2_b = 4'hE;
    #1;
    checkOutput("hold_glitch_0e", nm2_mayor, 4'h5);
    applyStimulus(4'h1, 4'hC);
    checkOutput("latency_second", nm2_mayor, 4'hC);

    // Asynchronous reset mid-run discards the pending result
    applyStimulus(4'hE, 4'h3);
    checkOutput("async_pre", nm2_mayor, 4'hE);
    #2;
    reset_L = 1'b0;
    #1;
    checkOutput("async_drop", nm2_mayor, 4'h0);
    nm2_a = 4'h7; nm2_b = 4'h1;
    @(posedge clk); #1;
    checkOutput("async_edge_in_reset", nm2_mayor, 4'h0);
    #2;
    reset_L = 1'b1;
    #1;
    checkOutput("async_released_wait", nm2_mayor, 4'h0);
    @(posedge clk); #1;
    checkOutput("async_first_load", nm2_mayor, 4'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
